// File: rtl/ysyx_23060025_lsu_axi_gen2.sv
`timescale 1ns/1ps
// Single-outstanding AXI4-Lite load/store unit with byte-lane steering and error reporting.
// Optional watchdog on stalled bus transactions: define LSU_TIMEOUT_EN.
module ysyx_23060025_lsu_axi_gen2 #(
  parameter int DATA_LEN       = 32,
  parameter int ADDR_LEN       = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_LEN-1:0]   req_addr_i,
  input  logic [DATA_LEN-1:0]   req_wdata_i,
  input  logic                  req_load_i,
  input  logic                  req_store_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_LEN-1:0]   resp_rdata_o,
  output logic [1:0]            resp_err_o,
  output logic [ADDR_LEN-1:0]   addr_r_addr_o,
  output logic [2:0]            addr_r_size_o,
  output logic                  addr_r_valid_o,
  input  logic                  addr_r_ready_i,
  input  logic [DATA_LEN-1:0]   r_data_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  output logic [ADDR_LEN-1:0]   addr_w_addr_o,
  output logic [2:0]            addr_w_size_o,
  output logic                  addr_w_valid_o,
  input  logic                  addr_w_ready_i,
  output logic [DATA_LEN-1:0]   w_data_o,
  output logic [DATA_LEN/8-1:0] w_strb_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  input  logic [1:0]            bkwd_resp_i,
  input  logic                  bkwd_valid_i,
  output logic                  bkwd_ready_o
);
  localparam int STRB_W = DATA_LEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_BUS   = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2, DONE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic                load_q, load_d;
  logic                signed_q, signed_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic                illegal_s;
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drain_q, drain_d;
`endif

  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a[1:0];
      2'd3:    misaligned = |a[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [OFF_W-1:0] off, input logic [1:0] sz);
    int lo;
    int hi;
    lo = int'(off);
    hi = lo + (32'sd1 << sz);
    for (int i = 0; i < STRB_W; i++) lane_strb[i] = (i >= lo) && (i < hi);
  endfunction

  // Truncate the lane-aligned beat to the access size, then zero/sign extend.
  function automatic logic [DATA_LEN-1:0] load_ext(input logic [DATA_LEN-1:0] raw,
                                                   input logic [1:0] sz, input logic sgn);
    int   nb;
    logic msb;
    nb  = 32'sd8 << sz;
    msb = 1'b0;
    for (int i = 0; i < DATA_LEN; i++) msb = (i == nb - 1) ? raw[i] : msb;
    for (int i = 0; i < DATA_LEN; i++) load_ext[i] = (i < nb) ? raw[i] : (sgn & msb);
  endfunction

  assign illegal_s = misaligned(req_addr_i[2:0], req_size_i)
                   | ((req_size_i == 2'd3) && (DATA_LEN == 32))
                   | (req_load_i & req_store_i);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    signed_d  = signed_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d     = cnt_q;
    drain_d   = drain_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          load_d    = req_load_i;
          signed_d  = req_signed_i;
          size_d    = req_size_i;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i << {req_addr_i[OFF_W-1:0], 3'b000};
          strb_d    = lane_strb(req_addr_i[OFF_W-1:0], req_size_i);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = ERR_OK;
`ifdef LSU_TIMEOUT_EN
          cnt_d     = '0;
          drain_d   = 1'b0;
`endif
          if (illegal_s) begin
            state_d = DONE;
            err_d   = ERR_ALIGN;
          end else if (!req_load_i && !req_store_i) begin
            state_d = DONE;
          end else begin
            state_d = ADDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (load_q) begin
          state_d = addr_r_ready_i ? RESP : ADDR;
        end else begin
          // AW and W complete independently; advance once both have fired.
          aw_done_d = aw_done_q | addr_w_ready_i;
          w_done_d  = w_done_q | w_ready_i;
          state_d   = (aw_done_d && w_done_d) ? RESP : ADDR;
        end
      end
      RESP: begin
        if (load_q && r_valid_i) begin
          state_d = DONE;
          rdata_d = load_ext(r_data_i >> {addr_q[OFF_W-1:0], 3'b000}, size_q, signed_q);
          err_d   = (r_resp_i != 2'b00) ? ERR_BUS : ERR_OK;
        end else if (!load_q && bkwd_valid_i) begin
          state_d = DONE;
          err_d   = (bkwd_resp_i != 2'b00) ? ERR_BUS : ERR_OK;
        end else begin
          state_d = RESP;
        end
      end
      DONE: begin
        state_d = resp_ready_i ? IDLE : DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef LSU_TIMEOUT_EN
    // A handshake in the final cycle wins over the watchdog.
    if (state_q == ADDR || state_q == RESP) begin
      cnt_d = cnt_q + 1'b1;
      if (state_d == state_q && cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        err_d   = ERR_TMO;
        drain_d = 1'b1;
      end else begin
        drain_d = drain_q;
      end
    end else begin
      cnt_d = cnt_d;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= '0;
      drain_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      signed_q  <= signed_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
`endif
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign resp_valid_o   = (state_q == DONE);
  assign resp_rdata_o   = rdata_q;
  assign resp_err_o     = err_q;
  assign addr_r_addr_o  = addr_q;
  assign addr_w_addr_o  = addr_q;
  assign addr_r_size_o  = {1'b0, size_q};
  assign addr_w_size_o  = {1'b0, size_q};
  assign w_data_o       = wdata_q;
  assign w_strb_o       = strb_q;
  assign addr_r_valid_o = (state_q == ADDR) && load_q;
  assign addr_w_valid_o = (state_q == ADDR) && !load_q && !aw_done_q;
  assign w_valid_o      = (state_q == ADDR) && !load_q && !w_done_q;
`ifdef LSU_TIMEOUT_EN
  // After a timeout, stray R/B beats are swallowed while idle.
  assign r_ready_o      = ((state_q == RESP) && load_q) || ((state_q == IDLE) && drain_q);
  assign bkwd_ready_o   = ((state_q == RESP) && !load_q) || ((state_q == IDLE) && drain_q);
`else
  assign r_ready_o      = (state_q == RESP) && load_q;
  assign bkwd_ready_o   = (state_q == RESP) && !load_q;
`endif

endmodule

// File: doc/ysyx_23060025_lsu_axi_gen2.md
Name: ysyx_23060025_lsu_axi_gen2

Overview:
Parametrised load/store unit. Takes one memory request at a time from EXU over a valid/ready request port and runs it as a single AXI4-Lite-style transaction (AR/R or AW/W/B). Returns load data or completion status to WBU over a valid/ready response port.
Next generation of the LSU: configurable data width, independent AW/W handshakes, lane steering for every address, and error reporting instead of hanging.

Parameters:
DATA_LEN, 32, bus and register data width; legal values 32 or 64.
ADDR_LEN, 32, address width.
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
clock  in  1  system clock; all logic on posedge.
rstn  in  1  asynchronous active-low reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  LSU can accept a request.
req_addr_i  in  ADDR_LEN  byte address.
req_wdata_i  in  DATA_LEN  store data, right-aligned.
req_load_i  in  1  request is a load.
req_store_i  in  1  request is a store.
req_size_i  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
req_signed_i  in  1  load result is sign-extended.
resp_valid_o  out  1  response valid.
resp_ready_i  in  1  WBU accepts the response.
resp_rdata_o  out  DATA_LEN  extended load data; 0 for stores.
resp_err_o  out  2  00=ok, 01=bus error, 10=misaligned/illegal, 11=timeout.
addr_r_addr_o, addr_r_size_o(3), addr_r_valid_o  out; addr_r_ready_i  in.
r_data_i(DATA_LEN), r_resp_i(2), r_valid_i  in; r_ready_o  out.
addr_w_addr_o, addr_w_size_o(3), addr_w_valid_o  out; addr_w_ready_i  in.
w_data_o(DATA_LEN), w_strb_o(DATA_LEN/8), w_valid_o  out; w_ready_i  in.
bkwd_resp_i(2), bkwd_valid_i  in; bkwd_ready_o  out.

Behaviour:
- Clock and reset (fixed): one clock, clock; rstn is asynchronous and active-low.
- rstn low, effective immediately and asynchronously:
  - state=IDLE; every valid/ready output 0 except req_ready_o.
  - All address/data/strobe outputs 0; resp_err_o=00; internal done flags and counters cleared.
- States: IDLE, ADDR, RESP, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch all request fields.
  - Misaligned request (addr not a multiple of 1<<size), size=3 when DATA_LEN=32, or load&store both set: go to DONE with err=10; no bus activity.
  - Neither load nor store set: go to DONE with err=00 and rdata=0.
  - Otherwise go to ADDR.
- ADDR, load: addr_r_valid_o=1 until addr_r_ready_i; then RESP.
- ADDR, store:
  - addr_w_valid_o and w_valid_o start together; each deasserts after its own handshake (aw_done, w_done flags).
  - Handshakes may complete in either order or in the same cycle.
  - Go to RESP in the cycle both are done.
- RESP, load: r_ready_o=1; on r_valid_i go to DONE, capturing the extended data and err=(r_resp_i!=0 ? 01 : 00).
- RESP, store: bkwd_ready_o=1; on bkwd_valid_i go to DONE with err=(bkwd_resp_i!=0 ? 01 : 00). A nonzero bkwd_resp_i never stalls the FSM.
- DONE: resp_valid_o=1; resp_rdata_o and resp_err_o held stable until resp_ready_i, then IDLE. No new request is accepted in DONE.
- Bus outputs (address, size, data, strobe) are driven from registers and stay stable while the matching valid is high.
- Lane offset off = addr[log2(DATA_LEN/8)-1:0].
- Store steering:
  - w_data_o = req_wdata << (8*off).
  - w_strb_o = ((1<<(1<<size))-1) << off.
  - addr_w_addr_o is the full unmasked address; *_size_o = req_size.
- Load steering:
  - raw = r_data_i >> (8*off).
  - Truncate raw to 8<<size bits, then zero- or sign-extend to DATA_LEN per req_signed.
- Minimum latency with slave ready=1 (accept = edge 0):
  - Load: valid in cycle 1, R beat in cycle 2, resp_valid_o in cycle 3.
  - Store: same timing with the B beat in cycle 2.
  - Error path: resp_valid_o in cycle 1.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to ADDR and increments every cycle in ADDR or RESP.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with err=11 and deassert all AXI valid/ready outputs.
  - Late beats arriving in IDLE are accepted and dropped.
- Undefined: no counter; the LSU waits forever in ADDR or RESP.

Test Plan:
1. LB, DATA_LEN=32, addr 0x80000003, r_data_i=0x80ABCDEF, slave always ready -> addr_r_size_o=0; resp_rdata_o=0xFFFFFF80, err 00, resp_valid_o in cycle 3.
2. SH addr 0x80000002, wdata 0x00001234; addr_w_ready_i at cycle 1, w_ready_i at cycle 4 -> w_data_o=0x12340000, w_strb_o=4'b1100; exactly one AW and one W handshake; resp after the B beat.
3. LW addr 0x80000001 -> no bus valid ever asserted; resp_valid_o in cycle 1 with err 10. DATA_LEN=64 LD at 0x...08 with r_data_i lane data -> full 64-bit result, err 00.
4. SW with bkwd_resp_i=2'b10 -> resp_err_o=01 and the LSU returns to IDLE (no hang). LW with r_resp_i=2'b11 -> err 01.
5. resp_ready_i held low for 4 cycles -> resp_valid_o, resp_rdata_o and resp_err_o stable; req_ready_o=0 throughout. rstn pulsed low mid-RESP -> all valids 0 asynchronously, FSM in IDLE after release.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, addr_r_ready_i tied 0 -> err 11 after 16 cycles; addr_r_valid_o drops; the next request is served normally.
